reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_if.sv | 46 ++++
 rtl/reorder_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Issue, result-broadcast and commit signals of the reorder buffer.
// The slave modport is the buffer itself; master is the surrounding pipeline.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 readyIn;
    logic                 issueValid;
    logic [1:0]           issueType;
    logic [4:0]           issueDest;
    logic                 issuePredTaken;
    logic [31:0]          issueAltPc;
    logic                 full;
    logic [ROB_WIDTH-1:0] nextIndex;

    logic                 rsUpdate;
    logic [ROB_WIDTH-1:0] rsRobIndex;
    logic [31:0]          rsUpdateVal;
    logic                 lsbUpdate;
    logic [ROB_WIDTH-1:0] lsbRobIndex;
    logic [31:0]          lsbUpdateVal;

    logic                 regWrite;
    logic [4:0]           regWriteDest;
    logic [ROB_WIDTH-1:0] regWriteRobId;
    logic [31:0]          regWriteVal;
    logic                 storeCommit;
    logic [ROB_WIDTH-1:0] storeRobId;
    logic                 clear;
    logic [31:0]          clearPc;

    modport master (
        output readyIn, issueValid, issueType, issueDest, issuePredTaken, issueAltPc,
        output rsUpdate, rsRobIndex, rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal,
        input  full, nextIndex,
        input  regWrite, regWriteDest, regWriteRobId, regWriteVal,
        input  storeCommit, storeRobId, clear, clearPc
    );

    modport slave (
        input  readyIn, issueValid, issueType, issueDest, issuePredTaken, issueAltPc,
        input  rsUpdate, rsRobIndex, rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal,
        output full, nextIndex,
        output regWrite, regWriteDest, regWriteRobId, regWriteVal,
        output storeCommit, storeRobId, clear, clearPc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular entry store, result capture from two
// broadcast ports, registered commit outputs and branch-mispredict flush.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic             clockIn,
    input  logic             resetIn,
    reorder_buffer_if.slave  rob
);
    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] DEPTH_C      = (ROB_WIDTH + 1)'(DEPTH);
    localparam logic [ROB_WIDTH:0] FULL_LEVEL_C = (ROB_WIDTH + 1)'(DEPTH - 1);

    typedef logic [ROB_WIDTH-1:0] idx_t;

    idx_t               head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0] count_q, count_d;

    logic               reg_write_q, reg_write_d;
    logic [4:0]         reg_write_dest_q, reg_write_dest_d;
    idx_t               reg_write_rob_id_q, reg_write_rob_id_d;
    logic [31:0]        reg_write_val_q, reg_write_val_d;
    logic               store_commit_q, store_commit_d;
    idx_t               store_rob_id_q, store_rob_id_d;
    logic               clear_q, clear_d;
    logic [31:0]        clear_pc_q, clear_pc_d;

    // Per-entry state exported for the head read port
    logic               ready_vec  [DEPTH];
    logic [1:0]         type_vec   [DEPTH];
    logic [4:0]         dest_vec   [DEPTH];
    logic               pred_vec   [DEPTH];
    logic [31:0]        alt_pc_vec [DEPTH];
    logic [31:0]        value_vec  [DEPTH];

    logic               upd_en, issue_fire, commit_fire, mispredict;
    logic [1:0]         head_type;
    logic [31:0]        head_value;

    // The cycle after a flush the pipeline is still draining: inputs are ignored
    assign upd_en      = !clear_q;
    assign issue_fire  = rob.issueValid && !clear_q && (count_q != DEPTH_C);
    assign head_type   = type_vec[head_q];
    assign head_value  = value_vec[head_q];
    assign commit_fire = (count_q != '0) && ready_vec[head_q];
    assign mispredict  = commit_fire && (head_type == 2'b10) &&
                         (head_value[0] != pred_vec[head_q]);

    assign rob.full      = (count_q >= FULL_LEVEL_C);
    assign rob.nextIndex = tail_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic        busy_q, busy_d, ready_q, ready_d, pred_q, pred_d;
            logic [1:0]  type_q, type_d;
            logic [4:0]  dest_q, dest_d;
            logic [31:0] alt_pc_q, alt_pc_d, value_q, value_d;
            logic        issue_hit, rs_hit, lsb_hit, commit_hit;

            always_comb begin
                issue_hit  = issue_fire && (tail_q == idx_t'(gi));
                rs_hit     = upd_en && rob.rsUpdate && busy_q && (rob.rsRobIndex == idx_t'(gi));
                lsb_hit    = upd_en && rob.lsbUpdate && busy_q && (rob.lsbRobIndex == idx_t'(gi));
                commit_hit = commit_fire && (head_q == idx_t'(gi));
                busy_d   = busy_q;
                ready_d  = ready_q;
                pred_d   = pred_q;
                type_d   = type_q;
                dest_d   = dest_q;
                alt_pc_d = alt_pc_q;
                value_d  = value_q;
                if (mispredict) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end else if (issue_hit) begin
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    type_d   = (rob.issueType == 2'b11) ? 2'b00 : rob.issueType;
                    dest_d   = rob.issueDest;
                    pred_d   = rob.issuePredTaken;
                    alt_pc_d = rob.issueAltPc;
                end else begin
                    // Load/store port has priority when both target this entry
                    if (lsb_hit) begin
                        ready_d = 1'b1;
                        value_d = rob.lsbUpdateVal;
                    end else if (rs_hit) begin
                        ready_d = 1'b1;
                        value_d = rob.rsUpdateVal;
                    end
                    if (commit_hit) begin
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clockIn) begin
                if (resetIn) begin
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b0;
                    pred_q   <= 1'b0;
                    type_q   <= 2'b00;
                    dest_q   <= '0;
                    alt_pc_q <= '0;
                    value_q  <= '0;
                end else if (rob.readyIn) begin
                    busy_q   <= busy_d;
                    ready_q  <= ready_d;
                    pred_q   <= pred_d;
                    type_q   <= type_d;
                    dest_q   <= dest_d;
                    alt_pc_q <= alt_pc_d;
                    value_q  <= value_d;
                end
            end

            assign ready_vec[gi]  = ready_q;
            assign type_vec[gi]   = type_q;
            assign dest_vec[gi]   = dest_q;
            assign pred_vec[gi]   = pred_q;
            assign alt_pc_vec[gi] = alt_pc_q;
            assign value_vec[gi]  = value_q;
        end
    endgenerate

    always_comb begin
        head_d  = head_q + idx_t'(commit_fire);
        tail_d  = tail_q + idx_t'(issue_fire);
        count_d = count_q + (ROB_WIDTH + 1)'(issue_fire) - (ROB_WIDTH + 1)'(commit_fire);
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Commit outputs are single-cycle pulses; data fields are zero when idle
    always_comb begin
        reg_write_d        = 1'b0;
        reg_write_dest_d   = '0;
        reg_write_rob_id_d = '0;
        reg_write_val_d    = '0;
        store_commit_d     = 1'b0;
        store_rob_id_d     = '0;
        clear_d            = 1'b0;
        clear_pc_d         = '0;
        if (commit_fire) begin
            unique case (head_type)
                2'b01: begin
                    store_commit_d = 1'b1;
                    store_rob_id_d = head_q;
                end
                2'b10: begin
                    if (mispredict) begin
                        clear_d    = 1'b1;
                        clear_pc_d = alt_pc_vec[head_q];
                    end
                end
                default: begin
                    reg_write_d        = 1'b1;
                    reg_write_dest_d   = dest_vec[head_q];
                    reg_write_rob_id_d = head_q;
                    reg_write_val_d    = head_value;
                end
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            reg_write_q        <= 1'b0;
            reg_write_dest_q   <= '0;
            reg_write_rob_id_q <= '0;
            reg_write_val_q    <= '0;
            store_commit_q     <= 1'b0;
            store_rob_id_q     <= '0;
            clear_q            <= 1'b0;
            clear_pc_q         <= '0;
        end else if (rob.readyIn) begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            reg_write_q        <= reg_write_d;
            reg_write_dest_q   <= reg_write_dest_d;
            reg_write_rob_id_q <= reg_write_rob_id_d;
            reg_write_val_q    <= reg_write_val_d;
            store_commit_q     <= store_commit_d;
            store_rob_id_q     <= store_rob_id_d;
            clear_q            <= clear_d;
            clear_pc_q         <= clear_pc_d;
        end
    end

    assign rob.regWrite      = reg_write_q;
    assign rob.regWriteDest  = reg_write_dest_q;
    assign rob.regWriteRobId = reg_write_rob_id_q;
    assign rob.regWriteVal   = reg_write_val_q;
    assign rob.storeCommit   = store_commit_q;
    assign rob.storeRobId    = store_rob_id_q;
    assign rob.clear         = clear_q;
    assign rob.clearPc       = clear_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed stimulus with a commit scoreboard: expected commits are queued as
// stimulus is issued, and a negedge monitor pops and compares each commit pulse.
module tb_reorder_buffer;
    logic clk;
    logic rst;

    reorder_buffer_if #(.ROB_WIDTH(4)) rob ();

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn (clk),
        .resetIn (rst),
        .rob     (rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 1 reg write, 2 store, 3 clear
        logic [4:0]  dest;
        logic [3:0]  id;
        logic [31:0] val;    // register value or redirect PC
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) prev_ready = rob.readyIn;

    // Monitor: only edges where the buffer was enabled can produce a new pulse
    always @(negedge clk) begin
        if (prev_ready && (rob.regWrite || rob.storeCommit || rob.clear)) begin
            int   kind;
            exp_t e;
            kind = rob.regWrite ? 1 : (rob.storeCommit ? 2 : 3);
            check("commit_onehot", 32'(rob.regWrite) + 32'(rob.storeCommit) + 32'(rob.clear), 32'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit actual_kind=%0d required=none", kind);
            end else begin
                e = sb.pop_front();
                check("commit_kind", 32'(kind), 32'(e.kind));
                if (e.kind == 1) begin
                    check("reg_dest", 32'(rob.regWriteDest), 32'(e.dest));
                    check("reg_robid", 32'(rob.regWriteRobId), 32'(e.id));
                    check("reg_val", rob.regWriteVal, e.val);
                end else if (e.kind == 2) begin
                    check("store_robid", 32'(rob.storeRobId), 32'(e.id));
                end else begin
                    check("clear_pc", rob.clearPc, e.val);
                end
                $display("commit kind=%0d robid/dest=%0d/%0d val=0x%0h", kind,
                         rob.regWriteRobId | rob.storeRobId, rob.regWriteDest,
                         rob.regWriteVal | rob.clearPc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob.issueValid = 1'b0;
        rob.rsUpdate   = 1'b0;
        rob.lsbUpdate  = 1'b0;
    endtask

    task automatic push(input int kind, input logic [4:0] dest, input logic [3:0] id,
                        input logic [31:0] val);
        exp_t e;
        e.kind = kind; e.dest = dest; e.id = id; e.val = val;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] dest, input logic pred,
                         input logic [31:0] alt);
        rob.issueValid = 1'b1; rob.issueType = t; rob.issueDest = dest;
        rob.issuePredTaken = pred; rob.issueAltPc = alt;
        tick();
        rob.issueValid = 1'b0;
    endtask

    task automatic rs_upd(input logic [3:0] idx, input logic [31:0] val);
        rob.rsUpdate = 1'b1; rob.rsRobIndex = idx; rob.rsUpdateVal = val;
        tick();
        rob.rsUpdate = 1'b0;
    endtask

    task automatic lsb_upd(input logic [3:0] idx, input logic [31:0] val);
        rob.lsbUpdate = 1'b1; rob.lsbRobIndex = idx; rob.lsbUpdateVal = val;
        tick();
        rob.lsbUpdate = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rob.readyIn = 1'b1;
        idle_inputs();
        rob.issueType = 2'b00; rob.issueDest = '0; rob.issuePredTaken = 1'b0; rob.issueAltPc = '0;
        rob.rsRobIndex = '0; rob.rsUpdateVal = '0; rob.lsbRobIndex = '0; rob.lsbUpdateVal = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_next_index", 32'(rob.nextIndex), 32'd0);
        check("rst_full", 32'(rob.full), 32'd0);
        check("rst_reg_write", 32'(rob.regWrite), 32'd0);
        check("rst_store", 32'(rob.storeCommit), 32'd0);
        check("rst_clear", 32'(rob.clear), 32'd0);

        // Single register write, two-cycle update-to-commit latency
        issue(2'b00, 5'd5, 1'b0, 32'h0);
        check("t1_next_index", 32'(rob.nextIndex), 32'd1);
        push(1, 5'd5, 4'd0, 32'h1234);
        rs_upd(4'd0, 32'h1234);
        check("t1_no_early_commit", 32'(rob.regWrite), 32'd0);
        tick();
        check("t1_commit_visible", 32'(rob.regWrite), 32'd1);
        drain(5);
        tick();
        check("t1_single_pulse", 32'(rob.regWrite), 32'd0);

        // Out-of-order completion, in-order commit
        reset_dut();
        issue(2'b00, 5'd3, 1'b0, 32'h0);
        issue(2'b00, 5'd4, 1'b0, 32'h0);
        rs_upd(4'd1, 32'hB);
        tick(); tick();
        push(1, 5'd3, 4'd0, 32'hA);
        push(1, 5'd4, 4'd1, 32'hB);
        rs_upd(4'd0, 32'hA);
        drain(6);

        // Full threshold and tail wrap
        reset_dut();
        for (int i = 0; i < 14; i++) issue(2'b00, 5'(i), 1'b0, 32'h0);
        check("t3_not_full_14", 32'(rob.full), 32'd0);
        issue(2'b00, 5'd14, 1'b0, 32'h0);
        check("t3_full_15", 32'(rob.full), 32'd1);
        check("t3_next_index_15", 32'(rob.nextIndex), 32'd15);
        push(1, 5'd0, 4'd0, 32'h100);
        rs_upd(4'd0, 32'h100);
        tick();
        check("t3_full_after_commit", 32'(rob.full), 32'd0);
        drain(4);
        issue(2'b00, 5'd15, 1'b0, 32'h0);
        check("t3_tail_wrap", 32'(rob.nextIndex), 32'd0);
        check("t3_full_again", 32'(rob.full), 32'd1);
        issue(2'b00, 5'd16, 1'b0, 32'h0);
        check("t3_next_index_16", 32'(rob.nextIndex), 32'd1);
        issue(2'b00, 5'd17, 1'b0, 32'h0);
        check("t3_issue_when_16_ignored", 32'(rob.nextIndex), 32'd1);

        // Branch mispredict flushes younger entries; issue during clear ignored
        reset_dut();
        issue(2'b10, 5'd0, 1'b0, 32'h80);
        issue(2'b00, 5'd6, 1'b0, 32'h0);
        push(3, 5'd0, 4'd0, 32'h80);
        rob.rsUpdate = 1'b1;  rob.rsRobIndex = 4'd0;  rob.rsUpdateVal = 32'h1;
        rob.lsbUpdate = 1'b1; rob.lsbRobIndex = 4'd1; rob.lsbUpdateVal = 32'h77;
        tick();
        idle_inputs();
        tick();
        check("t4_clear_high", 32'(rob.clear), 32'd1);
        rob.issueValid = 1'b1; rob.issueType = 2'b00; rob.issueDest = 5'd8;
        tick();
        idle_inputs();
        check("t4_clear_one_cycle", 32'(rob.clear), 32'd0);
        check("t4_issue_in_clear_ignored", 32'(rob.nextIndex), 32'd0);
        check("t4_empty_after_flush", 32'(rob.full), 32'd0);
        tick(); tick();
        issue(2'b10, 5'd0, 1'b1, 32'h200);
        lsb_upd(4'd0, 32'h1);
        tick(); tick(); tick();
        check("t4_correct_branch_no_clear", 32'(rob.clear), 32'd0);

        // Store commit and lsb priority on same-index update
        reset_dut();
        issue(2'b01, 5'd0, 1'b0, 32'h0);
        push(2, 5'd0, 4'd0, 32'h0);
        lsb_upd(4'd0, 32'hDEAD);
        drain(4);
        issue(2'b00, 5'd9, 1'b0, 32'h0);
        push(1, 5'd9, 4'd1, 32'h2222);
        rob.rsUpdate = 1'b1;  rob.rsRobIndex = 4'd1;  rob.rsUpdateVal = 32'h1111;
        rob.lsbUpdate = 1'b1; rob.lsbRobIndex = 4'd1; rob.lsbUpdateVal = 32'h2222;
        tick();
        idle_inputs();
        drain(4);

        // Stall with a ready head, then hold of a visible commit
        reset_dut();
        issue(2'b00, 5'd2, 1'b0, 32'h0);
        push(1, 5'd2, 4'd0, 32'h55);
        rs_upd(4'd0, 32'h55);
        rob.readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stall_no_commit", 32'(rob.regWrite), 32'd0);
        end
        rob.readyIn = 1'b1;
        tick();
        check("t6_commit_after_stall", 32'(rob.regWrite), 32'd1);
        rob.readyIn = 1'b0;
        tick(); tick();
        check("t6_output_held", 32'(rob.regWrite), 32'd1);
        check("t6_value_held", rob.regWriteVal, 32'h55);
        rob.readyIn = 1'b1;
        tick();
        check("t6_pulse_ends", 32'(rob.regWrite), 32'd0);
        drain(2);

        // Reset mid-stream, with readyIn low, cancels a pending commit
        issue(2'b00, 5'd1, 1'b0, 32'h0);
        rs_upd(4'd1, 32'h9);
        rob.readyIn = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rob.readyIn = 1'b1;
        check("t7_reg_write_zero", 32'(rob.regWrite), 32'd0);
        check("t7_reg_val_zero", rob.regWriteVal, 32'd0);
        check("t7_next_index_zero", 32'(rob.nextIndex), 32'd0);
        tick(); tick();
        check("t7_no_commit_after_reset", 32'(rob.regWrite), 32'd0);

        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
